// File: rtl/audio_pkg.sv
// Shared constants and types for the PCM volume/gain path.
package audio_pkg;

   localparam int DATA_W = 24;
   localparam int GAIN_W = 16;
   localparam int PROD_W = DATA_W + GAIN_W + 1;

   localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h8000;
   localparam logic [DATA_W-1:0] SAT_MAX    = 24'h7FFFFF;
   localparam logic [DATA_W-1:0] SAT_MIN    = 24'h800000;

   typedef enum logic [1:0] {IDLE, MULT, OUT} state_t;
   typedef enum logic {CH_L, CH_R} chan_t;

   typedef struct packed {
      chan_t             ch;
      logic [DATA_W-1:0] sample;
   } pcm_req_t;

endpackage

// File: rtl/pcm_gain_sat.sv
// Registered signed-sample x unsigned Q1.15 gain, then arithmetic shift and
// saturation back to DATA_W with a clip indication.
module pcm_gain_sat
   import audio_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ld,
   input  logic [DATA_W-1:0] sample,
   input  logic [GAIN_W-1:0] gain,
   output logic [DATA_W-1:0] res,
   output logic              clip
);

   logic signed [PROD_W-1:0] sample_ext, gain_ext, prod, shifted;
   logic                     ovf;

   assign sample_ext = {{(PROD_W-DATA_W){sample[DATA_W-1]}}, sample};
   assign gain_ext   = {{(PROD_W-GAIN_W){1'b0}}, gain};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         prod <= '0;
      else if (ld)
         prod <= sample_ext * gain_ext;
   end

   // Shift floors toward -inf; result fits only if all bits above the sign agree.
   assign shifted = prod >>> (GAIN_W - 1);
   assign ovf     = ~((&shifted[PROD_W-1:DATA_W-1]) | ~(|shifted[PROD_W-1:DATA_W-1]));
   assign clip    = ovf;
   assign res     = ovf ? (shifted[PROD_W-1] ? SAT_MIN : SAT_MAX) : shifted[DATA_W-1:0];

endmodule

// File: rtl/pcm_volume_ramp.sv
// Master volume / soft-mute stage: per-sample gain with click-free ramping.
// Optional macro VOL_ZERO_CROSS_EN restricts gain steps to left-channel zero crossings.
module pcm_volume_ramp
   import audio_pkg::*;
#(
   parameter logic [GAIN_W-1:0] RAMP_STEP = 16'h0010
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              audio_en,
   input  logic              vol_wr_en,
   input  logic [7:0]        vol_lsb,
   input  logic [7:0]        vol_msb,
   input  logic              mute,
   input  logic              clr_status,
   input  logic              l_data_en,
   input  logic              r_data_en,
   input  logic [DATA_W-1:0] l_data_in,
   input  logic [DATA_W-1:0] r_data_in,
   output logic              l_data_valid,
   output logic              r_data_valid,
   output logic [DATA_W-1:0] l_data_out,
   output logic [DATA_W-1:0] r_data_out,
   output logic              ramp_active,
   output logic              clip_flag,
   output logic              overrun_flag
);

   state_t            state, state_n;
   pcm_req_t          work;
   logic [DATA_W-1:0] l_buf, r_buf, res;
   logic              l_pend, r_pend, take_l, take_r, mult_ld, clip;
   logic [GAIN_W-1:0] target_gain, cur_gain, eff_gain, gain_diff, gain_inc, next_gain;
   logic              out_fire, step_ok, gain_step, ovr_set;

   assign eff_gain    = mute ? '0 : target_gain;
   assign ramp_active = (cur_gain != eff_gain);

   always_comb begin
      state_n = state;
      take_l  = 1'b0;
      take_r  = 1'b0;
      mult_ld = 1'b0;
      case (state)
         IDLE, OUT: begin
            state_n = IDLE;
            if (l_pend) begin
               take_l  = 1'b1;
               state_n = MULT;
            end else if (r_pend) begin
               take_r  = 1'b1;
               state_n = MULT;
            end
         end
         MULT: begin
            mult_ld = 1'b1;
            state_n = OUT;
         end
         default: state_n = IDLE;
      endcase
      if (!audio_en) begin
         state_n = IDLE;
         take_l  = 1'b0;
         take_r  = 1'b0;
         mult_ld = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   // A new strobe in the same cycle as a take re-arms pending without overrun.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         l_buf  <= '0;
         r_buf  <= '0;
         l_pend <= 1'b0;
         r_pend <= 1'b0;
      end else if (!audio_en) begin
         l_pend <= 1'b0;
         r_pend <= 1'b0;
      end else begin
         if (l_data_en) l_buf <= l_data_in;
         if (r_data_en) r_buf <= r_data_in;
         l_pend <= l_data_en | (l_pend & ~take_l);
         r_pend <= r_data_en | (r_pend & ~take_r);
      end
   end

   // Snapshot the selected sample so later overwrites of the buffer cannot leak in.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         work <= '0;
      else if (take_l)
         work <= '{ch: CH_L, sample: l_buf};
      else if (take_r)
         work <= '{ch: CH_R, sample: r_buf};
   end

   pcm_gain_sat u_gain_sat (
      .clk     (clk),
      .reset_n (reset_n),
      .ld      (mult_ld),
      .sample  (work.sample),
      .gain    (cur_gain),
      .res     (res),
      .clip    (clip)
   );

   assign out_fire = (state == OUT) & audio_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         l_data_valid <= 1'b0;
         r_data_valid <= 1'b0;
         l_data_out   <= '0;
         r_data_out   <= '0;
      end else begin
         l_data_valid <= 1'b0;
         r_data_valid <= 1'b0;
         if (out_fire) begin
            if (work.ch == CH_L) begin
               l_data_out   <= res;
               l_data_valid <= 1'b1;
            end else begin
               r_data_out   <= res;
               r_data_valid <= 1'b1;
            end
         end
      end
   end

   assign ovr_set = audio_en & ((l_data_en & l_pend & ~take_l) | (r_data_en & r_pend & ~take_r));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clip_flag    <= 1'b0;
         overrun_flag <= 1'b0;
      end else begin
         clip_flag    <= (clip_flag & ~clr_status) | (out_fire & clip);
         overrun_flag <= (overrun_flag & ~clr_status) | ovr_set;
      end
   end

   always_comb begin
      gain_diff = (eff_gain > cur_gain) ? eff_gain - cur_gain : cur_gain - eff_gain;
      gain_inc  = (gain_diff > RAMP_STEP) ? RAMP_STEP : gain_diff;
      next_gain = (eff_gain > cur_gain) ? cur_gain + gain_inc : cur_gain - gain_inc;
   end

`ifdef VOL_ZERO_CROSS_EN
   logic       prev_sign, cross_seen;
   logic [5:0] zc_cnt;

   // Crossing is judged on the left sample; the step lands with the right output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_sign  <= 1'b0;
         cross_seen <= 1'b0;
         zc_cnt     <= '0;
      end else if (out_fire) begin
         if (work.ch == CH_L) begin
            cross_seen <= (work.sample[DATA_W-1] != prev_sign) || (work.sample == '0);
            prev_sign  <= work.sample[DATA_W-1];
         end else begin
            cross_seen <= 1'b0;
            zc_cnt     <= step_ok ? '0 : zc_cnt + 6'd1;
         end
      end
   end

   assign step_ok = cross_seen | (zc_cnt == 6'd63);
`else
   assign step_ok = 1'b1;
`endif

   assign gain_step = out_fire & (work.ch == CH_R) & step_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         target_gain <= UNITY_GAIN;
         cur_gain    <= '0;
      end else begin
         if (vol_wr_en) target_gain <= {vol_msb, vol_lsb};
         if (!audio_en)
            cur_gain <= '0;
         else if (gain_step)
            cur_gain <= next_gain;
      end
   end

endmodule

// File: tb/tb_pcm_volume_ramp.sv
// Randomized bench for pcm_volume_ramp against an arithmetic frame-level model.
module tb_pcm_volume_ramp;

   logic        clk = 1'b0, reset_n = 1'b0, audio_en = 1'b1, vol_wr_en = 1'b0;
   logic        mute = 1'b0, clr_status = 1'b0, l_data_en = 1'b0, r_data_en = 1'b0;
   logic [7:0]  vol_lsb = '0, vol_msb = '0;
   logic [23:0] l_data_in = '0, r_data_in = '0;
   logic        l_data_valid, r_data_valid, ramp_active, clip_flag, overrun_flag;
   logic [23:0] l_data_out, r_data_out;

   int n_tests = 0, n_fail = 0;
   int mg = 0, mtarget = 'h8000;
   bit mmute = 0, mclip = 0;

   pcm_volume_ramp dut (
      .clk(clk), .reset_n(reset_n), .audio_en(audio_en), .vol_wr_en(vol_wr_en),
      .vol_lsb(vol_lsb), .vol_msb(vol_msb), .mute(mute), .clr_status(clr_status),
      .l_data_en(l_data_en), .r_data_en(r_data_en), .l_data_in(l_data_in), .r_data_in(r_data_in),
      .l_data_valid(l_data_valid), .r_data_valid(r_data_valid), .l_data_out(l_data_out),
      .r_data_out(r_data_out), .ramp_active(ramp_active), .clip_flag(clip_flag),
      .overrun_flag(overrun_flag)
   );

   always #5 clk = ~clk;

   function automatic int eff_g();
      return mmute ? 0 : mtarget;
   endfunction

   // floor(sample * gain / 2^15), clamped to the 24-bit signed range
   function automatic logic [23:0] ref_scale(input logic [23:0] s, input int g, output bit sat);
      longint p, q;
      p = longint'($signed(s)) * longint'(g);
      q = p / 32768;
      if (p < 0 && (p % 32768) != 0) q = q - 1;
      sat = 1'b0;
      if (q > 8388607) begin sat = 1'b1; q = 8388607; end
      else if (q < -8388608) begin sat = 1'b1; q = -8388608; end
      return q[23:0];
   endfunction

   function automatic int ref_step(input int g, input int e);
      if (e > g) return (e - g > 16) ? g + 16 : e;
      if (g > e) return (g - e > 16) ? g - 16 : e;
      return g;
   endfunction

   task automatic model_frame(input logic [23:0] ls, rs, output logic [23:0] el, er);
      bit sl, sr;
      el = ref_scale(ls, mg, sl);
      er = ref_scale(rs, mg, sr);
      mclip = mclip | sl | sr;
      mg = ref_step(mg, eff_g());
   endtask

   task automatic do_frame(input logic [23:0] ls, rs, output logic [23:0] lo, ro,
                           output int lk, rk, lw, rw);
      lo = '0; ro = '0; lk = -1; rk = -1; lw = 0; rw = 0;
      @(negedge clk); l_data_in = ls; r_data_in = rs; l_data_en = 1; r_data_en = 1;
      @(negedge clk); l_data_en = 0; r_data_en = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (l_data_valid) begin lw++; if (lk < 0) begin lk = k; lo = l_data_out; end end
         if (r_data_valid) begin rw++; if (rk < 0) begin rk = k; ro = r_data_out; end end
      end
   endtask

   task automatic write_vol(input logic [15:0] v);
      @(negedge clk); {vol_msb, vol_lsb} = v; vol_wr_en = 1;
      @(negedge clk); vol_wr_en = 0;
      mtarget = int'(v);
   endtask

   task automatic pulse_clr();
      @(negedge clk); clr_status = 1;
      @(negedge clk); clr_status = 0;
      mclip = 0;
   endtask

   task automatic test_reset();
      reset_n = 0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({l_data_valid, r_data_valid, clip_flag, overrun_flag} !== 4'b0 ||
          l_data_out !== 24'h0 || r_data_out !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b%b clip=%b ovr=%b l=%h r=%h, want all 0",
                  l_data_valid, r_data_valid, clip_flag, overrun_flag, l_data_out, r_data_out);
      end
      n_tests++;
      if (ramp_active !== (mg != eff_g())) begin
         n_fail++; $display("FAIL reset_ramp_active: got %b want %b", ramp_active, mg != eff_g());
      end
      reset_n = 1;
   endtask

   task automatic test_fade_in();
      logic [23:0] ls, rs, el, er, lo, ro;
      int lk, rk, lw, rw;
      ls = 24'h100000; rs = 24'($urandom);
      model_frame(ls, rs, el, er);
      do_frame(ls, rs, lo, ro, lk, rk, lw, rw);
      n_tests++;
      if (lo !== el || ro !== er) begin
         n_fail++; $display("FAIL fade_first: got l=%h r=%h want l=%h r=%h", lo, ro, el, er);
      end
      n_tests++;
      if (lk != 3 || rk != 5 || lw != 1 || rw != 1) begin
         n_fail++;
         $display("FAIL latency: got l@%0d x%0d r@%0d x%0d, want l@3 x1 r@5 x1", lk, lw, rk, rw);
      end
      for (int i = 0; i < 2047; i++) begin
         ls = 24'($urandom); rs = 24'($urandom);
         model_frame(ls, rs, el, er);
         do_frame(ls, rs, lo, ro, lk, rk, lw, rw);
         n_tests++;
         if (lo !== el || ro !== er || lk != 3 || rk != 5) begin
            n_fail++;
            $display("FAIL fade_ramp[%0d]: got l=%h r=%h lat=%0d/%0d want l=%h r=%h lat=3/5",
                     i, lo, ro, lk, rk, el, er);
         end
      end
      n_tests++;
      if (ramp_active !== 1'b0 || mg != eff_g()) begin
         n_fail++; $display("FAIL fade_done: ramp_active=%b model_gain=%h want 0 / %h", ramp_active, mg, eff_g());
      end
      ls = 24'h100000; rs = 24'($urandom);
      model_frame(ls, rs, el, er);
      do_frame(ls, rs, lo, ro, lk, rk, lw, rw);
      n_tests++;
      if (lo !== el || ro !== er) begin
         n_fail++; $display("FAIL unity_out: got l=%h r=%h want l=%h r=%h", lo, ro, el, er);
      end
   endtask

   task automatic test_boost_clip();
      logic [23:0] ls, rs, el, er, lo, ro;
      int lk, rk, lw, rw;
      write_vol(16'hFFFF);
      for (int i = 0; i < 2048; i++) begin
         ls = 24'($urandom); rs = 24'($urandom);
         model_frame(ls, rs, el, er);
         do_frame(ls, rs, lo, ro, lk, rk, lw, rw);
         n_tests++;
         if (lo !== el || ro !== er || lk != 3 || rk != 5) begin
            n_fail++;
            $display("FAIL boost_ramp[%0d]: got l=%h r=%h lat=%0d/%0d want l=%h r=%h lat=3/5",
                     i, lo, ro, lk, rk, el, er);
         end
      end
      n_tests++;
      if (ramp_active !== 1'b0) begin
         n_fail++; $display("FAIL boost_done: ramp_active=%b want 0", ramp_active);
      end
      pulse_clr();
      n_tests++;
      if (clip_flag !== 1'b0) begin
         n_fail++; $display("FAIL clr_before_clip: clip_flag=%b want 0", clip_flag);
      end
      model_frame(24'h7FFFFF, 24'h800000, el, er);
      do_frame(24'h7FFFFF, 24'h800000, lo, ro, lk, rk, lw, rw);
      n_tests++;
      if (lo !== el || ro !== er || clip_flag !== mclip) begin
         n_fail++;
         $display("FAIL clip_sat: got l=%h r=%h clip=%b want l=%h r=%h clip=%b",
                  lo, ro, clip_flag, el, er, mclip);
      end
      pulse_clr();
      n_tests++;
      if (clip_flag !== 1'b0) begin
         n_fail++; $display("FAIL clr_status: clip_flag=%b want 0", clip_flag);
      end
   endtask

   task automatic test_overrun();
      logic [23:0] rs, la, lb, el, er, lo, ro;
      bit s;
      int lw = 0, rw = 0;
      n_tests++;
      if (overrun_flag !== 1'b0) begin
         n_fail++; $display("FAIL overrun_idle: overrun_flag=%b want 0", overrun_flag);
      end
      rs = 24'($urandom); la = 24'($urandom); lb = 24'($urandom);
      er = ref_scale(rs, mg, s); mclip |= s;
      mg = ref_step(mg, eff_g());
      el = ref_scale(lb, mg, s); mclip |= s;
      lo = '0; ro = '0;
      @(negedge clk); r_data_in = rs; r_data_en = 1;
      @(negedge clk); r_data_en = 0; l_data_in = la; l_data_en = 1;
      @(negedge clk); l_data_in = lb;
      @(negedge clk); l_data_en = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (l_data_valid) begin lw++; lo = l_data_out; end
         if (r_data_valid) begin rw++; ro = r_data_out; end
      end
      n_tests++;
      if (lo !== el || ro !== er || lw != 1 || rw != 1 || overrun_flag !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun: got l=%h x%0d r=%h x%0d ovr=%b want l=%h x1 r=%h x1 ovr=1",
                  lo, lw, ro, rw, overrun_flag, el, er);
      end
      pulse_clr();
      n_tests++;
      if (overrun_flag !== 1'b0) begin
         n_fail++; $display("FAIL overrun_clr: overrun_flag=%b want 0", overrun_flag);
      end
   endtask

   task automatic test_mute();
      logic [23:0] ls, rs, el, er, lo, ro;
      int lk, rk, lw, rw;
      write_vol(16'h8000);
      for (int i = 0; i < 4096; i++) begin
         if (i == 2048) begin
            @(negedge clk); mute = 1; mmute = 1;
         end
         ls = 24'($urandom); rs = 24'($urandom);
         model_frame(ls, rs, el, er);
         do_frame(ls, rs, lo, ro, lk, rk, lw, rw);
         n_tests++;
         if (lo !== el || ro !== er || lk != 3 || rk != 5) begin
            n_fail++;
            $display("FAIL mute_ramp[%0d]: got l=%h r=%h lat=%0d/%0d want l=%h r=%h lat=3/5",
                     i, lo, ro, lk, rk, el, er);
         end
      end
      n_tests++;
      if (ramp_active !== 1'b0 || mg != 0) begin
         n_fail++; $display("FAIL mute_done: ramp_active=%b model_gain=%h want 0 / 0", ramp_active, mg);
      end
      model_frame(24'h100000, 24'h100000, el, er);
      do_frame(24'h100000, 24'h100000, lo, ro, lk, rk, lw, rw);
      n_tests++;
      if (lo !== el || ro !== er || clip_flag !== mclip) begin
         n_fail++;
         $display("FAIL mute_out: got l=%h r=%h clip=%b want l=%h r=%h clip=%b",
                  lo, ro, clip_flag, el, er, mclip);
      end
   endtask

   task automatic test_audio_en_drop();
      logic [23:0] ls, rs, el, er, lo, ro, held;
      int lk, rk, lw, rw, nv = 0;
      @(negedge clk); mute = 0; mmute = 0;
      for (int i = 0; i < 20; i++) begin
         ls = 24'($urandom); rs = 24'($urandom);
         model_frame(ls, rs, el, er);
         do_frame(ls, rs, lo, ro, lk, rk, lw, rw);
         n_tests++;
         if (lo !== el || ro !== er) begin
            n_fail++; $display("FAIL unmute_ramp[%0d]: got l=%h r=%h want l=%h r=%h", i, lo, ro, el, er);
         end
      end
      held = l_data_out;
      @(negedge clk); l_data_in = 24'($urandom); l_data_en = 1;
      @(negedge clk); l_data_en = 0; audio_en = 0; mg = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (l_data_valid || r_data_valid) nv++;
      end
      n_tests++;
      if (nv != 0 || l_data_out !== held || ramp_active !== (mg != eff_g())) begin
         n_fail++;
         $display("FAIL en_drop: valids=%0d l=%h ramp=%b want valids=0 l=%h ramp=%b",
                  nv, l_data_out, ramp_active, held, mg != eff_g());
      end
      @(negedge clk); audio_en = 1;
      ls = 24'($urandom); rs = 24'($urandom);
      model_frame(ls, rs, el, er);
      do_frame(ls, rs, lo, ro, lk, rk, lw, rw);
      n_tests++;
      if (lo !== el || ro !== er || lk != 3 || rk != 5 || ramp_active !== (mg != eff_g())) begin
         n_fail++;
         $display("FAIL en_resume: got l=%h r=%h lat=%0d/%0d ramp=%b want l=%h r=%h lat=3/5 ramp=%b",
                  lo, ro, lk, rk, ramp_active, el, er, mg != eff_g());
      end
   endtask

   initial begin
      test_reset();
      test_fade_in();
      test_boost_clip();
      test_overrun();
      test_mute();
      test_audio_en_drop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
